alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/rr_arbiter_2.sv | 16 +
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared ALU opcodes, FSM state type and width default for alu_arbiter
package alu_arb_pkg;

  localparam int DATA_W_DEFAULT = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant from request valids and last-grant bit
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbitrates two requesters onto one shared combinational ALU
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result
);

  arb_state_t        state;
  logic              last_grant;
  logic              owner;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [1:0]        grant;
  logic              idle_ok;
  logic              resp_done;

  rr_arbiter_2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // rst_n is active-high; handshakes are masked while it is asserted.
  assign idle_ok    = (state == IDLE) && !rst_n;
  assign req0_ready = idle_ok && grant[0];
  assign req1_ready = idle_ok && grant[1];

  assign resp0_valid  = (state == RESP) && !rst_n && !owner;
  assign resp1_valid  = (state == RESP) && !rst_n && owner;
  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;
  assign resp_done    = owner ? resp1_ready : resp0_ready;

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= ALU_AND;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= grant[1];
            op_q  <= grant[1] ? req1_op : req0_op;
            a_q   <= grant[1] ? req1_a  : req0_a;
            b_q   <= grant[1] ? req1_b  : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= (alu_result == '0);
          state    <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with external ALU and reference model
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp0_valid, resp0_ready, resp0_zero;
  logic         resp1_valid, resp1_ready, resp1_zero;
  logic [W-1:0] resp0_result, resp1_result;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_control;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_last   = 1;

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      default: return a + b;
    endcase
  endfunction

  // The shared ALU lives outside the arbiter.
  assign alu_result = ref_alu(alu_control, alu_a, alu_b);

  alu_arbiter #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_zero   (resp0_zero),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_zero   (resp1_zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_last = 1;
  endtask

  // Runs one arbitration round from IDLE and reports what was observed; callers judge it.
  task automatic txn(input bit v0, input bit v1,
                     input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input int bp,
                     output int gnt, output int lat, output int rown,
                     output logic [W-1:0] res, output logic zf,
                     output bit held, output bit leak, output bit cleared);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    if (req0_ready && !req1_ready)      gnt = 0;
    else if (req1_ready && !req0_ready) gnt = 1;
    else                                gnt = -1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!resp0_valid && !resp1_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rown = (resp0_valid && resp1_valid) ? 2 : resp0_valid ? 0 : resp1_valid ? 1 : -1;
    res  = resp1_valid ? resp1_result : resp0_result;
    zf   = resp1_valid ? resp1_zero : resp0_zero;
    held = 1'b1;
    leak = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < bp; k++) begin
      #1;
      if (req0_ready || req1_ready) leak = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (rown == 0 && (!resp0_valid || resp0_result !== res || resp0_zero !== zf)) held = 1'b0;
      if (rown == 1 && (!resp1_valid || resp1_result !== res || resp1_zero !== zf)) held = 1'b0;
    end
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = (rown == 0);
    resp1_ready = (rown == 1);
    @(posedge clk);
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    cleared = !resp0_valid && !resp1_valid;
    if (rown < 0 || rown > 1) begin
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      model_last = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_handshake: rdy0/rdy1/rv0/rv1=%b want 0000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (alu_a !== '0 || alu_b !== '0 || alu_control !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_alu_regs: a=%h b=%h ctl=%b want 0", alu_a, alu_b, alu_control);
    end
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single();
    int gnt, lat, rown;
    logic [W-1:0] res;
    logic zf;
    bit held, leak, cleared;
    txn(1, 0, ALU_ADD, 64'd5, 64'd7, ALU_AND, 64'd0, 64'd0, 0,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (gnt !== 0 || rown !== 0) begin
      tests_failed++;
      $display("FAIL single_owner: grant=%0d resp=%0d want 0/0", gnt, rown);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d want 2", lat);
    end
    tests_run++;
    if (res !== 64'd12 || zf !== 1'b0 || !cleared) begin
      tests_failed++;
      $display("FAIL single_result: res=%0d zero=%b cleared=%b want 12/0/1", res, zf, cleared);
    end
    model_last = 0;
    req0_op = ALU_SUB; req0_a = 64'd99; req0_b = 64'd1;
    req1_op = ALU_OR;  req1_a = 64'd42; req1_b = 64'd3;
    #1;
    tests_run++;
    if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_control !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL alu_hold: a=%0d b=%0d ctl=%b want 5/7/0010", alu_a, alu_b, alu_control);
    end
  endtask

  task automatic test_simultaneous();
    int gnt, lat, rown;
    logic [W-1:0] res;
    logic zf;
    bit held, leak, cleared;
    do_reset();
    txn(1, 1, ALU_SUB, 64'd9, 64'd9, ALU_OR, 64'hF0, 64'h0F, 0,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (gnt !== 0 || rown !== 0 || res !== '0 || zf !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_first: grant=%0d resp=%0d res=%h zero=%b want 0/0/0/1", gnt, rown, res, zf);
    end
    txn(0, 1, ALU_SUB, 64'd9, 64'd9, ALU_OR, 64'hF0, 64'h0F, 0,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (gnt !== 1 || rown !== 1 || res !== 64'hFF || zf !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_second: grant=%0d resp=%0d res=%h zero=%b want 1/1/ff/0", gnt, rown, res, zf);
    end
    model_last = 1;
  endtask

  task automatic test_round_robin();
    int gnt, lat, rown;
    logic [W-1:0] res, exp_res;
    logic zf;
    bit held, leak, cleared;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, ALU_ADD, 64'(i), 64'd100, ALU_SUB, 64'(i + 50), 64'd1, 0,
          gnt, lat, rown, res, zf, held, leak, cleared);
      exp_res = (i % 2 == 0) ? 64'(i + 100) : 64'(i + 49);
      tests_run++;
      if (gnt !== i % 2 || rown !== i % 2 || res !== exp_res) begin
        tests_failed++;
        $display("FAIL rr_op%0d: grant=%0d resp=%0d res=%0d want %0d/%0d/%0d",
                 i, gnt, rown, res, i % 2, i % 2, exp_res);
      end
    end
    model_last = 1;
  endtask

  task automatic test_backpressure();
    int gnt, lat, rown;
    logic [W-1:0] res;
    logic zf;
    bit held, leak, cleared;
    txn(0, 1, ALU_AND, 64'd1, 64'd1, ALU_OR, 64'h1234, 64'h00F0, 5,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (gnt !== 1 || rown !== 1 || res !== 64'h12F4) begin
      tests_failed++;
      $display("FAIL bp_result: grant=%0d resp=%0d res=%h want 1/1/12f4", gnt, rown, res);
    end
    tests_run++;
    if (!held || leak || !cleared) begin
      tests_failed++;
      $display("FAIL bp_hold: held=%b ready_leak=%b cleared=%b want 1/0/1", held, leak, cleared);
    end
    model_last = 1;
  endtask

  task automatic test_reset_exec();
    int gnt, lat, rown;
    logic [W-1:0] res;
    logic zf;
    bit held, leak, cleared, bad;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 64'd3; req0_b = 64'd4;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (resp0_valid || resp1_valid || alu_a !== '0 || alu_b !== '0 || alu_control !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_exec_clear: rv0=%b rv1=%b a=%h b=%h ctl=%b want all 0",
               resp0_valid, resp1_valid, alu_a, alu_b, alu_control);
    end
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp0_valid || resp1_valid) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rst_exec_noresp: stale response seen=%b want 0", bad);
    end
    txn(1, 1, ALU_OR, 64'd8, 64'd1, ALU_AND, 64'd3, 64'd1, 0,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (gnt !== 0 || rown !== 0 || res !== 64'd9) begin
      tests_failed++;
      $display("FAIL rst_exec_first: grant=%0d resp=%0d res=%0d want 0/0/9", gnt, rown, res);
    end
    model_last = 0;
  endtask

  task automatic test_wrap();
    int gnt, lat, rown;
    logic [W-1:0] res;
    logic zf;
    bit held, leak, cleared;
    txn(1, 0, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_AND, 64'd0, 64'd0, 0,
        gnt, lat, rown, res, zf, held, leak, cleared);
    tests_run++;
    if (res !== '0 || zf !== 1'b1 || rown !== 0) begin
      tests_failed++;
      $display("FAIL wrap: res=%h zero=%b resp=%0d want 0/1/0", res, zf, rown);
    end
    model_last = 0;
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] tab [4];
    int r;
    tab = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB};
    r = $urandom_range(4, 0);
    if (r == 4) return 4'($urandom_range(15, 0));
    return tab[r];
  endfunction

  task automatic test_random();
    int gnt, lat, rown, pick, bp, exp_g;
    logic [W-1:0] res, exp_r, a0, b0, a1, b1;
    logic [3:0] op0, op1;
    logic zf;
    bit held, leak, cleared, v0, v1;
    for (int i = 0; i < 30; i++) begin
      pick = $urandom_range(2, 0);
      v0 = (pick != 1);
      v1 = (pick != 0);
      op0 = rand_op(); op1 = rand_op();
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) begin b0 = a0; b1 = a1; end
      bp = $urandom_range(3, 0);
      exp_g = (v0 && v1) ? 1 - model_last : (v0 ? 0 : 1);
      exp_r = (exp_g == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      txn(v0, v1, op0, a0, b0, op1, a1, b1, bp,
          gnt, lat, rown, res, zf, held, leak, cleared);
      tests_run++;
      if (gnt !== exp_g || rown !== exp_g || lat !== 2 || res !== exp_r ||
          zf !== (exp_r == '0) || !held || leak || !cleared) begin
        tests_failed++;
        $display("FAIL random_%0d: grant=%0d resp=%0d lat=%0d res=%h zero=%b held=%b leak=%b clr=%b want grant=%0d lat=2 res=%h",
                 i, gnt, rown, lat, res, zf, held, leak, cleared, exp_g, exp_r);
      end
      model_last = exp_g;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
